// File: rtl/alu_divider_if.sv
// Start/busy/done handshake and operand/result bus between the control sequencer and the divider.
// Vectors are [0:WIDTH-1] to match the datapath; bit 0 carries the LSB.
interface alu_divider_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [0:WIDTH-1] dividend;
    logic [0:WIDTH-1] divisor;
    logic             busy;
    logic             done;
    logic [0:WIDTH-1] quotient;
    logic [0:WIDTH-1] remainder;
    logic             div_zero;

    modport master (
        output start, dividend, divisor,
        input  busy, done, quotient, remainder, div_zero
    );

    modport slave (
        input  start, dividend, divisor,
        output busy, done, quotient, remainder, div_zero
    );
endinterface

// File: rtl/alu_divider.sv
// Sequential unsigned restoring divider: one trial subtraction per clock, WIDTH cycles per result,
// with a one-cycle divide-by-zero path. Results are held in DONE until the next accepted start.
module alu_divider #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_divider_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH:0]   p_q, p_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CW-1:0]    count_q, count_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;

    logic [WIDTH-1:0] dvd_in, dvs_in;
    logic [WIDTH:0]   shifted, trial;

    // Bus index i carries weight 2**i, so map bit-by-bit rather than by vector position.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit_map
        assign dvd_in[i]        = bus.dividend[i];
        assign dvs_in[i]        = bus.divisor[i];
        assign bus.quotient[i]  = quo_q[i];
        assign bus.remainder[i] = rem_q[i];
    end

    assign bus.busy     = (state_q == RUN);
    assign bus.done     = (state_q == DONE);
    assign bus.div_zero = dz_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            dvs_q   <= '0;
            count_q <= '0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rem_q   <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            dvs_q   <= dvs_d;
            count_q <= count_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dz_q    <= dz_d;
        end
    end

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case can infer a latch.
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        dvs_d   = dvs_q;
        count_d = count_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
        dz_d    = dz_q;

        // P stays below the divisor, so its top bit is always 0 and can be dropped by the shift.
        shifted = {p_q[WIDTH-1:0], q_q[WIDTH-1]};
        trial   = shifted - {1'b0, dvs_q};

        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = RUN;
                    dvs_d   = dvs_in;
                    q_d     = dvd_in;
                    p_d     = '0;
                    count_d = CW'(WIDTH);
                    zero_d  = (dvs_in == '0);
                end
            end
            RUN: begin
                if (zero_q) begin
                    state_d = DONE;
                    quo_d   = '1;
                    rem_d   = q_q;
                    dz_d    = 1'b1;
                end else begin
                    if (!trial[WIDTH]) begin
                        p_d = trial;
                        q_d = {q_q[WIDTH-2:0], 1'b1};
                    end else begin
                        p_d = shifted;
                        q_d = {q_q[WIDTH-2:0], 1'b0};
                    end
                    count_d = count_q - CW'(1);
                    if (count_q == CW'(1)) begin
                        state_d = DONE;
                        quo_d   = q_d;
                        rem_d   = p_d[WIDTH-1:0];
                        dz_d    = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_alu_divider.sv
// Self-checking bench for alu_divider: a latency/arithmetic reference model compared every cycle,
// directed boundary cases with literal expectations, and randomized operand pairs.
module tb_alu_divider;
    localparam int W    = 8;
    localparam int ONES = (1 << W) - 1;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    alu_divider_if #(.WIDTH(W)) bus ();

    alu_divider #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_en = 1'b0;

    // Model state: visible outputs plus the pending result and cycles left until it appears.
    bit m_busy, m_done, m_dz, p_dz;
    int m_q, m_r, p_q, p_r, m_left;

    function automatic logic [0:W-1] to_port(input int v);
        logic [0:W-1] r;
        for (int i = 0; i < W; i++) r[i] = v[i];
        return r;
    endfunction

    function automatic int from_port(input logic [0:W-1] p);
        int r = 0;
        for (int i = 0; i < W; i++) r[i] = p[i];
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_done <= 1'b0; m_dz <= 1'b0;
            m_q <= 0; m_r <= 0; m_left <= 0;
        end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_busy <= 1'b0; m_done <= 1'b1;
                m_q <= p_q; m_r <= p_r; m_dz <= p_dz;
            end
        end else if (bus.start) begin
            m_busy <= 1'b1;
            m_done <= 1'b0;
            if (from_port(bus.divisor) == 0) begin
                p_q <= ONES; p_r <= from_port(bus.dividend); p_dz <= 1'b1; m_left <= 1;
            end else begin
                p_q <= from_port(bus.dividend) / from_port(bus.divisor);
                p_r <= from_port(bus.dividend) % from_port(bus.divisor);
                p_dz <= 1'b0; m_left <= W;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy", int'(bus.busy), int'(m_busy));
            check("done", int'(bus.done), int'(m_done));
            check("quotient", from_port(bus.quotient), m_q);
            check("remainder", from_port(bus.remainder), m_r);
            check("div_zero", int'(bus.div_zero), int'(m_dz));
            check("busy_and_done", int'(bus.busy && bus.done), 0);
        end
    end

    // Called at a negedge; returns at the following negedge, just after the accepting edge.
    task automatic start_op(input int a, input int b);
        bus.start    = 1'b1;
        bus.dividend = to_port(a);
        bus.divisor  = to_port(b);
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // n0 = negedges already elapsed since the accepting edge (negedge n follows edge k+n-1).
    task automatic wait_result(input string name, input int n0, input int eq, input int er,
                               input int edz, input int elat);
        int n = n0;
        while (!bus.done && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({name, "_latency"}, n - 1, elat);
        check({name, "_q"}, from_port(bus.quotient), eq);
        check({name, "_r"}, from_port(bus.remainder), er);
        check({name, "_dz"}, int'(bus.div_zero), edz);
    endtask

    task automatic run_div(input string name, input int a, input int b, input int eq,
                           input int er, input int edz, input int elat);
        start_op(a, b);
        wait_result(name, 1, eq, er, edz, elat);
    endtask

    initial begin
        bus.start    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", int'(bus.busy), 0);
        check("reset_done", int'(bus.done), 0);
        check("reset_q", from_port(bus.quotient), 0);
        check("reset_r", from_port(bus.remainder), 0);
        check("reset_dz", int'(bus.div_zero), 0);
        rst_n  = 1'b1;
        cmp_en = 1'b1;
        @(negedge clk);

        start_op(200, 7);
        check("basic_busy", int'(bus.busy), 1);
        wait_result("basic", 1, 28, 4, 0, 8);

        run_div("b2b_255_1", 255, 1, 255, 0, 0, 8);
        run_div("b2b_5_9", 5, 9, 0, 5, 0, 8);
        run_div("b2b_0_3", 0, 3, 0, 0, 0, 8);

        run_div("divzero", 77, 0, 255, 77, 1, 1);
        run_div("after_dz", 10, 3, 3, 1, 0, 8);

        // A start arriving while busy must be dropped, not queued.
        start_op(100, 10);
        @(negedge clk);
        bus.start    = 1'b1;
        bus.dividend = to_port(50);
        bus.divisor  = to_port(5);
        @(negedge clk);
        bus.start = 1'b0;
        wait_result("ignored", 3, 10, 0, 0, 8);
        repeat (12) @(negedge clk);
        check("ignored_hold_done", int'(bus.done), 1);
        check("ignored_hold_q", from_port(bus.quotient), 10);

        start_op(200, 7);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        check("abort_q", from_port(bus.quotient), 0);
        check("abort_r", from_port(bus.remainder), 0);
        check("abort_dz", int'(bus.div_zero), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("abort_no_done", int'(bus.done), 0);
        run_div("after_reset", 9, 2, 4, 1, 0, 8);

        for (int i = 0; i < 1000; i++) begin
            int a, b;
            a = $urandom_range(0, ONES);
            b = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, ONES);
            repeat ($urandom_range(0, 2)) @(negedge clk);
            if (b == 0) run_div("rand", a, b, ONES, a, 1, 1);
            else        run_div("rand", a, b, a / b, a % b, 0, W);
        end

        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
